// File: rtl/sequenced_selecter_controller.sv
// Registered, handshaked datapath-select sequencer: decodes one instruction per
// transaction into mux switches and write enable, stalls for memory ops, latches halt.
module sequenced_selecter_controller #(
  parameter int         OP_WIDTH  = 16,
  parameter int         MEM_WAIT  = 1,
  parameter logic [3:0] HALT_FUNC = 4'b1111,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 op_valid,
  input  logic [OP_WIDTH-1:0]  op,
  output logic                 op_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [6:0]           switch,
  output logic                 write_order,
  output logic                 halted,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {IDLE, WAIT, OUT, HALT} state_t;

  localparam logic [3:0] WAIT_LD  = 4'(MEM_WAIT);
  localparam bit         HAS_WAIT = (MEM_WAIT > 0);

  state_t               state, state_nxt;
  logic [3:0]           cnt_p1;
  logic [6:0]           sw_p1;
  logic                 wo_p1;
  logic                 halt_p1;
  logic [CNT_WIDTH-1:0] retired_p1;
  logic                 accept;
  logic                 op_is_mem;
  logic                 op_is_halt;
  logic [7:0]           dec;
  logic                 op_unused;

  // Returns {switch[6:0], write_order} for one instruction word.
  function automatic logic [7:0] decode(input logic [OP_WIDTH-1:0] w);
    logic [1:0] cls;
    logic [2:0] cond;
    logic [3:0] fn;
    logic [7:0] r;
    cls  = w[OP_WIDTH-1 -: 2];
    cond = w[OP_WIDTH-3 -: 3];
    fn   = w[7:4];
    r    = 8'b0;
    case (cls)
      2'b00: r = {7'b0010100, 1'b1};
      2'b01: r = {7'b0100100, 1'b1};
      2'b10: begin
        case (cond)
          3'b000, 3'b001, 3'b010: r = {7'b0000100, 1'b1};
          3'b101:                 r = {7'b0000101, 1'b0};
          3'b110:                 r = {7'b1000111, 1'b1};
          default:                r = {7'b0000111, 1'b0};
        endcase
      end
      default: begin
        case (fn)
          4'd12:                        r = {7'b0011000, 1'b1};
          4'd5, 4'd7, 4'd13, 4'd14, 4'd15: r = {7'b0000000, 1'b0};
          default:                      r = {7'b0000000, 1'b1};
        endcase
      end
    endcase
    return r;
  endfunction

  assign op_unused  = ^op;
  assign dec        = decode(op);
  assign op_is_mem  = (op[OP_WIDTH-1] == 1'b0);
  assign op_is_halt = (op[OP_WIDTH-1 -: 2] == 2'b11) && (op[7:4] == HALT_FUNC);
  assign accept     = (state == IDLE) && op_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (op_valid) state_nxt = (op_is_mem && HAS_WAIT) ? WAIT : OUT;
      WAIT: if (cnt_p1 <= 4'd1) state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = halt_p1 ? HALT : IDLE;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: decode captured at acceptance, held until the next acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt_p1     <= 4'd0;
      sw_p1      <= 7'd0;
      wo_p1      <= 1'b0;
      halt_p1    <= 1'b0;
      retired_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sw_p1   <= dec[7:1];
        wo_p1   <= dec[0];
        halt_p1 <= op_is_halt;
        cnt_p1  <= WAIT_LD;
      end else if (state == WAIT) begin
        cnt_p1 <= cnt_p1 - 4'd1;
      end
      if ((state == OUT) && out_ready) retired_p1 <= retired_p1 + CNT_WIDTH'(1);
    end
  end

  assign op_ready    = (state == IDLE);
  assign out_valid   = (state == OUT);
  assign halted      = (state == HALT);
  assign busy        = (state == WAIT) || (state == OUT);
  assign switch      = sw_p1;
  assign write_order = wo_p1;
  assign retired     = retired_p1;

endmodule

// File: tb/tb_sequenced_selecter_controller.sv
// Scoreboard bench: stimulus pushes expected {switch, write_order}, a monitor pops
// and compares on every out_valid && out_ready handshake; directed checks cover timing.
module tb_sequenced_selecter_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [15:0] op;
  logic        op_ready;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  switch;
  logic        write_order;
  logic        halted;
  logic        busy;
  logic [15:0] retired;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  sequenced_selecter_controller #(
    .OP_WIDTH(16), .MEM_WAIT(2), .HALT_FUNC(4'b1111), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .out_ready(out_ready), .out_valid(out_valid), .switch(switch),
    .write_order(write_order), .halted(halted), .busy(busy), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare presented decode against the scoreboard on each handshake.
  always @(negedge clock) begin
    logic [7:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mon_switch", {25'd0, switch}, {25'd0, e[7:1]});
        chk("mon_write_order", {31'd0, write_order}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Two-cycle transaction for non-memory ops with out_ready held high.
  task automatic run_op(input logic [15:0] w, input logic [6:0] sw, input logic wo);
    exp_q.push_back({sw, wo});
    op = w; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
  endtask

  logic [15:0] wo_c11_mask;
  logic [6:0]  sw_c10 [8];
  logic        wo_c10 [8];

  initial begin
    wo_c11_mask = 16'h1F5F;
    sw_c10 = '{7'b0000100, 7'b0000100, 7'b0000100, 7'b0000111,
               7'b0000111, 7'b0000101, 7'b1000111, 7'b0000111};
    wo_c10 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; op_valid = 1'b0; op = 16'h0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_switch", {25'd0, switch}, 32'd0);
    chk("rst_write_order", {31'd0, write_order}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);

    // Class 11 func 1100, immediate consume.
    tick();
    out_ready = 1'b1;
    exp_q.push_back({7'b0011000, 1'b1});
    op = 16'hC0C0; op_valid = 1'b1;
    @(negedge clock);
    chk("c0c0_op_ready_accept", {31'd0, op_ready}, 32'd1);
    tick(); op_valid = 1'b0;
    @(negedge clock);
    chk("c0c0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c0c0_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clock);
    chk("c0c0_retired", {16'd0, retired}, 32'd1);
    chk("c0c0_out_valid_drop", {31'd0, out_valid}, 32'd0);

    // Load with MEM_WAIT=2: two stall cycles, then OUT.
    exp_q.push_back({7'b0010100, 1'b1});
    op = 16'h0000; op_valid = 1'b1;
    tick(); op_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("ld_wait_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ld_wait_switch", {25'd0, switch}, {25'd0, 7'b0010100});
      chk("ld_wait_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    @(negedge clock);
    chk("ld_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_out_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clock);
    chk("ld_retired", {16'd0, retired}, 32'd2);

    // Class 10 cond 110 with back-pressure; op_valid during hold ignored.
    out_ready = 1'b0;
    exp_q.push_back({7'b1000111, 1'b1});
    op = 16'hB000; op_valid = 1'b1;
    tick();
    op = 16'hC0C0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_switch", {25'd0, switch}, {25'd0, 7'b1000111});
      chk("hold_write_order", {31'd0, write_order}, 32'd1);
      chk("hold_op_ready", {31'd0, op_ready}, 32'd0);
      tick();
    end
    op_valid = 1'b0; out_ready = 1'b1;
    tick();
    @(negedge clock);
    chk("hold_retired", {16'd0, retired}, 32'd3);
    chk("hold_back_idle", {31'd0, op_ready}, 32'd1);

    // Decode sweep: class 11 func 0..14, class 10 cond 0..7.
    for (int f = 0; f < 15; f++) begin
      run_op({2'b11, 6'd0, 4'(f), 4'd0}, (f == 12) ? 7'b0011000 : 7'b0000000, wo_c11_mask[f]);
    end
    for (int c = 0; c < 8; c++) begin
      run_op({2'b10, 3'(c), 11'd0}, sw_c10[c], wo_c10[c]);
    end
    @(negedge clock);
    chk("sweep_retired", {16'd0, retired}, 32'd26);

    // Halt instruction: one OUT with write_order=0, then sticky HALT.
    exp_q.push_back({7'b0000000, 1'b0});
    op = 16'hC0F0; op_valid = 1'b1;
    tick(); op_valid = 1'b0;
    @(negedge clock);
    chk("halt_out_valid", {31'd0, out_valid}, 32'd1);
    chk("halt_write_order", {31'd0, write_order}, 32'd0);
    tick();
    op = 16'hC0C0; op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("halted_flag", {31'd0, halted}, 32'd1);
      chk("halted_op_ready", {31'd0, op_ready}, 32'd0);
      chk("halted_out_valid", {31'd0, out_valid}, 32'd0);
      chk("halted_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    chk("halt_retired", {16'd0, retired}, 32'd27);
    op_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_retired", {16'd0, retired}, 32'd0);
    chk("halt_rst_op_ready", {31'd0, op_ready}, 32'd1);

    // Reset in the middle of a load stall, then a store.
    op = 16'h0000; op_valid = 1'b1;
    tick(); op_valid = 1'b0;
    @(negedge clock);
    chk("abort_in_wait", {31'd0, busy && !out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_op_ready", {31'd0, op_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_switch", {25'd0, switch}, 32'd0);
    chk("abort_write_order", {31'd0, write_order}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back({7'b0100100, 1'b1});
    op = 16'h4000; op_valid = 1'b1;
    tick(); op_valid = 1'b0;
    @(negedge clock);
    chk("st_wait", {31'd0, out_valid}, 32'd0);
    tick(); tick();
    @(negedge clock);
    chk("st_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    @(negedge clock);
    chk("st_retired", {16'd0, retired}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
